mc_datapath_param: RTL and testbench

Parametrised multicycle MIPS datapath. It is the next generation of the fixed 32-bit multicycle datapath. Compared with that block it adds:
- configurable data width and register-file depth
- a memory ready/wait-state handshake that stalls every architectural register update
- BNE support
- JAL link writeback
- a hardwired zero register

It sits between the multicycle controller FSM and a unified instruction/data memory.

---
 rtl/mc_datapath_param.sv | 206 ++++++++++++++++++++
 tb/tb_mc_datapath_param.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_param.sv
// ---------------------------------------------------------------------------
// mc_datapath_param
//
// Parametrised multicycle MIPS datapath. The datapath sits between the
// multicycle controller FSM and a unified instruction/data memory. It holds
// the architectural registers: PC, IR, MDR, A, B, ALUOut and the register
// file. Any memory request that is waiting for mem_ready freezes all of that
// state.
//
// Parameters
//   DATA_W   datapath width (32..64); instructions are always 32 bits
//   NREG     register count (8/16/32); the link register is NREG-1
//   RESET_PC PC value loaded on reset
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   mem_rdata       memory read data (instruction or data)
//   mem_ready       memory completes the current access this cycle
//   mem_addr        IorD ? ALUOut : PC
//   mem_wdata       B register (store data)
//   mem_req/mem_we  access request / write strobe
//   ir_write, mem_read, mem_write, IorD, reg_dst, mem_to_reg, reg_write,
//   alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_write, pc_write_cond,
//   branch_ne       control inputs from the controller FSM
//   instr           IR contents for decode
//   zero            combinational ALU result == 0
//   stall           memory request waiting on mem_ready
// ---------------------------------------------------------------------------
module mc_datapath_param #(
  parameter int                DATA_W   = 32,
  parameter int                NREG     = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              ir_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              IorD,
  input  logic [1:0]        reg_dst,
  input  logic [1:0]        mem_to_reg,
  input  logic              reg_write,
  input  logic              alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic [2:0]        alu_ctrl,
  input  logic [1:0]        pc_src,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              branch_ne,
  output logic [31:0]       instr,
  output logic              zero,
  output logic              stall
);

  localparam int RW = $clog2(NREG);

  // ALU: all operations wrap modulo 2^DATA_W; set-less-than results are
  // zero-extended single bits.
  function automatic logic [DATA_W-1:0] alu_op(input logic [2:0]        op,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] xs;
    logic signed [DATA_W-1:0] ys;
    logic [DATA_W-1:0]        r;
    xs = x;
    ys = y;
    case (op)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x + y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x | y);
      3'b101:  r = {{(DATA_W-1){1'b0}}, (x < y)};
      3'b110:  r = x - y;
      default: r = {{(DATA_W-1){1'b0}}, (xs < ys)};
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] rf_q [NREG];

  logic [RW-1:0]     rs_idx, rt_idx, rd_idx, wr_idx;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [DATA_W-1:0] imm_sx, jump_tgt;
  logic [DATA_W-1:0] src_a_val, src_b_val, alu_res;
  logic [DATA_W-1:0] pc_mux, wr_data;
  logic              pc_en, rf_we;

  assign mem_req   = ir_write | mem_read | mem_write;
  assign mem_we    = mem_write;
  assign stall     = mem_req & ~mem_ready;
  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign instr     = ir_q;

  // Register specifiers use only the low log2(NREG) bits of each field.
  assign rs_idx = ir_q[21 +: RW];
  assign rt_idx = ir_q[16 +: RW];
  assign rd_idx = ir_q[11 +: RW];

  assign imm_sx   = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_tgt = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};

  // Register 0 is hardwired: it is never written, and reads are forced to 0.
  assign rs_val = (rs_idx == '0) ? '0 : rf_q[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : rf_q[rt_idx];

  always_comb begin
    src_a_val = alu_src_a ? a_q : pc_q;
    case (alu_src_b)
      2'b00:   src_b_val = b_q;
      2'b01:   src_b_val = {{(DATA_W-3){1'b0}}, 3'b100};
      2'b10:   src_b_val = imm_sx;
      default: src_b_val = {imm_sx[DATA_W-3:0], 2'b00};
    endcase
    alu_res = alu_op(alu_ctrl, src_a_val, src_b_val);
    zero    = (alu_res == '0);
  end

  always_comb begin
    case (pc_src)
      2'b00:   pc_mux = alu_res;
      2'b01:   pc_mux = jump_tgt;
      2'b10:   pc_mux = aluout_q;
      default: pc_mux = a_q;
    endcase
    // zero ^ branch_ne selects BEQ (taken on equal) or BNE (taken on unequal).
    pc_en = ~stall & (pc_write | (pc_write_cond & (zero ^ branch_ne)));
  end

  always_comb begin
    case (reg_dst)
      2'b01:   wr_idx = rd_idx;
      2'b10:   wr_idx = {RW{1'b1}};
      default: wr_idx = rt_idx;
    endcase
    case (mem_to_reg)
      2'b01:   wr_data = mdr_q;
      2'b10:   wr_data = pc_q;
      default: wr_data = aluout_q;
    endcase
    rf_we = reg_write & ~stall & (wr_idx != '0);
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    if (pc_en) begin
      pc_d = pc_mux;
    end
    if (ir_write & mem_ready) begin
      ir_d = mem_rdata[31:0];
    end
    if (mem_read & mem_ready) begin
      mdr_d = mem_rdata;
    end
    if (!stall) begin
      a_d      = rs_val;
      b_d      = rt_val;
      aluout_d = alu_res;
    end
  end

  // Architectural state: every register, including the register file, is
  // cleared asynchronously so a reset during a stalled access abandons it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      if (rf_we) begin
        rf_q[wr_idx] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mc_datapath_param.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath_param
//
// Bench acting as the multicycle controller for two datapath instances that
// share all control inputs: a 32-bit / 32-register instance and a 64-bit /
// 16-register instance, both with RESET_PC = 0x100. Expected values come from
// an instruction-level model (PC, register file, ALU semantics).
// ---------------------------------------------------------------------------
module tb_mc_datapath_param;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_SLTU = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_SLT  = 3'd7;
  localparam logic [31:0] RPC    = 32'h100;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] rdata;
  logic ready, ir_write, mem_read, mem_write, iord, reg_write, src_a;
  logic pc_write, pc_write_cond, branch_ne;
  logic [1:0] reg_dst, mem_to_reg, src_b, pc_src;
  logic [2:0] alu_ctrl;

  logic [31:0] addr32, wdata32, instr32;
  logic        req32, we32, zero32, stall32;
  logic [63:0] addr64, wdata64;
  logic [31:0] instr64;
  logic        req64, we64, zero64, stall64;

  logic [31:0] m_pc, m_ir;
  logic [31:0] m_rf [32];
  logic [63:0] w_pc;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_datapath_param #(.DATA_W(32), .NREG(32), .RESET_PC(32'h100)) dut32 (
    .clk(clk), .rst(rst), .mem_rdata(rdata[31:0]), .mem_ready(ready),
    .mem_addr(addr32), .mem_wdata(wdata32), .mem_req(req32), .mem_we(we32),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .IorD(iord),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(src_a), .alu_src_b(src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .instr(instr32), .zero(zero32), .stall(stall32)
  );

  mc_datapath_param #(.DATA_W(64), .NREG(16), .RESET_PC(64'h100)) dut64 (
    .clk(clk), .rst(rst), .mem_rdata(rdata), .mem_ready(ready),
    .mem_addr(addr64), .mem_wdata(wdata64), .mem_req(req64), .mem_we(we64),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .IorD(iord),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(src_a), .alu_src_b(src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .instr(instr64), .zero(zero64), .stall(stall64)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SUB:  return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clr();
    ir_write = 0; mem_read = 0; mem_write = 0; iord = 0; reg_dst = 0;
    mem_to_reg = 0; reg_write = 0; src_a = 0; src_b = 0; alu_ctrl = 0;
    pc_src = 0; pc_write = 0; pc_write_cond = 0; branch_ne = 0; ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_ir = '0; w_pc = 64'h100;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  // Instruction fetch with an optional number of wait states.
  task automatic fetch(input logic [31:0] word, input int waits);
    clr(); ir_write = 1; pc_write = 1; src_b = 2'b01; alu_ctrl = OP_ADD;
    for (int i = 0; i < waits; i++) begin
      rdata = {32'h0, ~word}; ready = 1'b0; #1;
      n_checks++;
      if (stall32 !== 1'b1) $display("FAIL fetch_stall: got %b want 1", stall32); else n_pass++;
      tick();
      n_checks++;
      if (addr32 !== m_pc) $display("FAIL fetch_pc_hold: got %h want %h", addr32, m_pc); else n_pass++;
      n_checks++;
      if (instr32 !== m_ir) $display("FAIL fetch_ir_hold: got %h want %h", instr32, m_ir); else n_pass++;
    end
    rdata = {32'hC0DE_0000, word}; ready = 1'b1; #1;
    n_checks++;
    if (stall32 !== 1'b0) $display("FAIL fetch_ready_stall: got %b want 0", stall32); else n_pass++;
    tick();
    m_pc = m_pc + 32'd4; m_ir = word;
    n_checks++;
    if (instr32 !== word) $display("FAIL fetch_ir: got %h want %h", instr32, word); else n_pass++;
    n_checks++;
    if (addr32 !== m_pc) $display("FAIL fetch_pc: got %h want %h", addr32, m_pc); else n_pass++;
  endtask

  task automatic decode();
    clr(); src_b = 2'b11; alu_ctrl = OP_ADD;
    tick();
  endtask

  // lw r, 0(r0) with the memory returning v.
  task automatic load_reg(input logic [4:0] r, input logic [31:0] v);
    fetch(enc_i(6'h23, 5'd0, r, 16'h0), 0);
    decode();
    clr(); src_a = 1; src_b = 2'b10; alu_ctrl = OP_ADD;
    tick();
    clr(); iord = 1; mem_read = 1; src_a = 1; src_b = 2'b10; alu_ctrl = OP_ADD;
    rdata = {32'h0, v}; ready = 1'b1; #1;
    n_checks++;
    if (addr32 !== 32'h0) $display("FAIL lw_addr: got %h want 0", addr32); else n_pass++;
    tick();
    clr(); mem_to_reg = 2'b01; reg_write = 1;
    tick();
    if (r != 5'd0) m_rf[r] = v;
  endtask

  // Reads register r onto B (mem_wdata) and compares with the model.
  task automatic observe_reg(input logic [4:0] r);
    fetch(enc_r(5'd0, r, 5'd0), 0);
    decode();
    n_checks++;
    if (wdata32 !== m_rf[r]) $display("FAIL reg_r%0d: got %h want %h", r, wdata32, m_rf[r]); else n_pass++;
  endtask

  task automatic run_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] op);
    logic [31:0] exp;
    exp = ref_alu(op, m_rf[rs], m_rf[rt]);
    fetch(enc_r(rs, rt, rd), 0);
    decode();
    clr(); src_a = 1; alu_ctrl = op; #1;
    n_checks++;
    if (zero32 !== (exp == 32'h0)) $display("FAIL alu_zero op%0d: got %b want %b", op, zero32, exp == 32'h0); else n_pass++;
    tick();
    clr(); iord = 1; reg_dst = 2'b01; reg_write = 1; #1;
    n_checks++;
    if (addr32 !== exp) $display("FAIL alu_result op%0d: got %h want %h", op, addr32, exp); else n_pass++;
    tick();
    if (rd != 5'd0) m_rf[rd] = exp;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    n_checks++;
    if (addr32 !== RPC) $display("FAIL reset_pc: got %h want %h", addr32, RPC); else n_pass++;
    n_checks++;
    if (instr32 !== 32'h0) $display("FAIL reset_ir: got %h want 0", instr32); else n_pass++;
    n_checks++;
    if (stall32 !== 1'b0 || req32 !== 1'b0) $display("FAIL reset_stall: got %b%b want 00", stall32, req32); else n_pass++;
    v = $urandom | 32'h1;
    load_reg(5'd3, v);
    observe_reg(5'd3);
    // Start a fetch that never completes, then reset in the middle of the cycle.
    clr(); ir_write = 1; pc_write = 1; src_b = 2'b01; alu_ctrl = OP_ADD;
    rdata = 64'h1234_5678; ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; #1;
    n_checks++;
    if (addr32 !== RPC) $display("FAIL async_reset_pc: got %h want %h", addr32, RPC); else n_pass++;
    n_checks++;
    if (instr32 !== 32'h0) $display("FAIL async_reset_ir: got %h want 0", instr32); else n_pass++;
    n_checks++;
    if (wdata32 !== 32'h0) $display("FAIL async_reset_b: got %h want 0", wdata32); else n_pass++;
    n_checks++;
    if (addr64 !== 64'h100) $display("FAIL async_reset_pc64: got %h want 100", addr64); else n_pass++;
    clr(); #1;
    n_checks++;
    if (stall32 !== 1'b0) $display("FAIL reset_idle_stall: got %b want 0", stall32); else n_pass++;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (addr32 !== RPC) $display("FAIL release_pc: got %h want %h", addr32, RPC); else n_pass++;
    observe_reg(5'd3);
  endtask

  task automatic test_fetch_wait();
    do_reset();
    fetch(32'h0123_4567 ^ $urandom, 3);
  endtask

  task automatic test_rtype();
    do_reset();
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd7);
    run_rtype(5'd1, 5'd2, 5'd3, OP_ADD);
    observe_reg(5'd3);
    run_rtype(5'd1, 5'd2, 5'd3, OP_SUB);
    observe_reg(5'd3);
    run_rtype(5'd3, 5'd1, 5'd4, OP_SLT);
    observe_reg(5'd4);
    run_rtype(5'd3, 5'd1, 5'd5, OP_SLTU);
    observe_reg(5'd5);
  endtask

  task automatic test_alu_random();
    logic [4:0] rs, rt, rd;
    logic [31:0] va, vb;
    logic [2:0] op;
    for (int i = 0; i < 16; i++) begin
      rs = 5'($urandom_range(1, 15));
      rt = 5'($urandom_range(1, 15));
      rd = 5'($urandom_range(0, 15));
      op = 3'(i % 8);
      va = $urandom;
      vb = (i % 5 == 0) ? va : $urandom;
      load_reg(rs, va);
      load_reg(rt, vb);
      run_rtype(rs, rt, rd, op);
      observe_reg(rd);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a, b, target;
    logic [15:0] off;
    logic bne;
    for (int k = 0; k < 6; k++) begin
      bne = k[0];
      if (k < 4) begin
        a = 32'd9;
        b = (k < 2) ? 32'd9 : 32'd8;
      end else begin
        a = $urandom;
        b = (k == 4) ? a : $urandom;
      end
      load_reg(5'd1, a);
      load_reg(5'd2, b);
      off = 16'($urandom);
      fetch(enc_i(bne ? 6'h05 : 6'h04, 5'd1, 5'd2, off), 0);
      target = m_pc + {{14{off[15]}}, off, 2'b00};
      decode();
      clr(); src_a = 1; alu_ctrl = OP_SUB; pc_write_cond = 1; branch_ne = bne;
      pc_src = 2'b10; iord = 1; #1;
      n_checks++;
      if (zero32 !== (a == b)) $display("FAIL br_zero k%0d: got %b want %b", k, zero32, a == b); else n_pass++;
      n_checks++;
      if (addr32 !== target) $display("FAIL br_target k%0d: got %h want %h", k, addr32, target); else n_pass++;
      tick();
      iord = 0; #1;
      if ((a == b) ^ bne) m_pc = target;
      n_checks++;
      if (addr32 !== m_pc) $display("FAIL br_pc k%0d: got %h want %h", k, addr32, m_pc); else n_pass++;
    end
  endtask

  task automatic test_jal_r0();
    logic [25:0] t;
    do_reset();
    load_reg(5'd4, 32'h200);
    fetch(enc_r(5'd4, 5'd0, 5'd0), 0);
    decode();
    clr(); pc_write = 1; pc_src = 2'b11;
    tick();
    m_pc = 32'h200;
    n_checks++;
    if (addr32 !== m_pc) $display("FAIL jr_pc: got %h want %h", addr32, m_pc); else n_pass++;
    t = 26'($urandom);
    fetch({6'h03, t}, 0);
    decode();
    clr(); pc_write = 1; pc_src = 2'b01; reg_dst = 2'b10; mem_to_reg = 2'b10; reg_write = 1;
    tick();
    m_rf[31] = m_pc;
    m_pc = {m_pc[31:28], t, 2'b00};
    n_checks++;
    if (addr32 !== m_pc) $display("FAIL jal_pc: got %h want %h", addr32, m_pc); else n_pass++;
    observe_reg(5'd31);
    load_reg(5'd0, 32'h0000_FFFF);
    observe_reg(5'd0);
    load_reg(5'd6, 32'hFFFF_0000);
    run_rtype(5'd6, 5'd4, 5'd0, OP_OR);
    observe_reg(5'd0);
  endtask

  task automatic test_store();
    logic [31:0] v;
    v = $urandom;
    load_reg(5'd6, v);
    fetch(enc_i(6'h2b, 5'd0, 5'd6, 16'h0040), 0);
    decode();
    clr(); src_a = 1; src_b = 2'b10; alu_ctrl = OP_ADD;
    tick();
    clr(); iord = 1; mem_write = 1; ready = 1'b0; #1;
    n_checks++;
    if (we32 !== 1'b1 || req32 !== 1'b1 || stall32 !== 1'b1)
      $display("FAIL sw_ctrl: got we%b req%b stall%b want 111", we32, req32, stall32);
    else n_pass++;
    n_checks++;
    if (addr32 !== 32'h40) $display("FAIL sw_addr: got %h want 40", addr32); else n_pass++;
    n_checks++;
    if (wdata32 !== v) $display("FAIL sw_data: got %h want %h", wdata32, v); else n_pass++;
    tick();
    ready = 1'b1; #1;
    n_checks++;
    if (stall32 !== 1'b0) $display("FAIL sw_ready: got %b want 0", stall32); else n_pass++;
    tick();
  endtask

  task automatic test_wide();
    logic [15:0] imm, imm2;
    logic [63:0] addr, val, sx2;
    do_reset();
    imm  = 16'h8000 | 16'($urandom_range(0, 32767));
    addr = {{48{imm[15]}}, imm};
    val  = {$urandom, $urandom};
    fetch(enc_i(6'h23, 5'd0, 5'd5, imm), 0);
    w_pc = w_pc + 64'd4;
    n_checks++;
    if (instr64 !== m_ir) $display("FAIL w_ir: got %h want %h", instr64, m_ir); else n_pass++;
    n_checks++;
    if (addr64 !== w_pc) $display("FAIL w_fetch_pc: got %h want %h", addr64, w_pc); else n_pass++;
    decode();
    clr(); src_a = 1; src_b = 2'b10; alu_ctrl = OP_ADD;
    tick();
    // Load access with two wait states; the ALU and PC are set up to change
    // so that any update leaking through the stall is visible.
    clr(); iord = 1; mem_read = 1; pc_write = 1; src_b = 2'b01; alu_ctrl = OP_ADD;
    for (int i = 0; i < 2; i++) begin
      rdata = ~val; ready = 1'b0; #1;
      n_checks++;
      if (stall64 !== 1'b1 || req64 !== 1'b1 || we64 !== 1'b0)
        $display("FAIL w_stall: got stall%b req%b we%b want 110", stall64, req64, we64);
      else n_pass++;
      tick();
      n_checks++;
      if (addr64 !== addr) $display("FAIL w_aluout_hold: got %h want %h", addr64, addr); else n_pass++;
    end
    rdata = val; ready = 1'b1; #1;
    n_checks++;
    if (stall64 !== 1'b0) $display("FAIL w_ready: got %b want 0", stall64); else n_pass++;
    tick();
    w_pc = w_pc + 64'd4; m_pc = m_pc + 32'd4;
    iord = 0; #1;
    n_checks++;
    if (addr64 !== w_pc) $display("FAIL w_pc_once: got %h want %h", addr64, w_pc); else n_pass++;
    clr(); mem_to_reg = 2'b01; reg_write = 1;
    tick();
    m_rf[5] = val[31:0];
    imm2 = 16'($urandom) | 16'h0001;
    sx2  = {{48{imm2[15]}}, imm2};
    fetch(enc_i(6'h08, 5'd0, 5'd9, imm2), 0);
    decode();
    clr(); src_a = 1; src_b = 2'b10; alu_ctrl = OP_ADD; #1;
    n_checks++;
    if (zero64 !== 1'b0) $display("FAIL w_zero: got %b want 0", zero64); else n_pass++;
    tick();
    clr(); reg_dst = 2'b10; reg_write = 1; iord = 1; #1;
    n_checks++;
    if (addr64 !== sx2) $display("FAIL w_imm_sx: got %h want %h", addr64, sx2); else n_pass++;
    tick();
    m_rf[31] = sx2[31:0];
    observe_reg(5'd5);
    n_checks++;
    if (wdata64 !== val) $display("FAIL w_mdr_r5: got %h want %h", wdata64, val); else n_pass++;
    observe_reg(5'd31);
    n_checks++;
    if (wdata64 !== sx2) $display("FAIL w_link_r15: got %h want %h", wdata64, sx2); else n_pass++;
    // Field value 21 selects r5 in a 16-register file.
    observe_reg(5'd21);
    n_checks++;
    if (wdata64 !== val) $display("FAIL w_idx_wrap: got %h want %h", wdata64, val); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rdata = '0;
    clr();
    model_reset();
    test_reset();
    test_fetch_wait();
    test_rtype();
    test_alu_random();
    test_branch();
    test_jal_r0();
    test_store();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
